context_save_stack: RTL and testbench

CONTEXT_SAVE_STACK -- requirements
Module: context_save_stack

---
 rtl/context_save_stack.sv | 108 ++++++++++
 tb/tb_context_save_stack.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_save_stack.sv
// LIFO context-save stack for nested interrupt entry/return.
// All state updates on the falling edge of clk; status outputs are combinational.
module context_save_stack #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int            IW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             unf;

  logic             is_empty;
  logic             is_full;
  logic [IW-1:0]    top_idx;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [CW-1:0]    cnt_next;
  logic             ovf_evt;
  logic             unf_evt;

  // Status decode and top-of-stack index from the registered count.
  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == DEPTH_C);
    top_idx  = IW'(cnt - CW'(1));
  end

  // Next-state decision for one push/pop request.
  // Push+pop on a non-empty stack overwrites the top in place; on an empty
  // stack it degenerates to a plain push.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = IW'(cnt);
    cnt_next = cnt;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (push && pop && !is_empty) begin
      wr_en   = 1'b1;
      wr_addr = top_idx;
    end else if (push) begin
      if (!is_full) begin
        wr_en    = 1'b1;
        cnt_next = cnt + CW'(1);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        cnt_next = cnt - CW'(1);
      end else begin
        unf_evt = 1'b1;
      end
    end
  end

  // Storage array: cleared on reset, written on accepted push or top replace.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= push_data;
    end
  end

  // Count and sticky error flags; a new error beats a simultaneous clear.
  always_ff @(negedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_evt | (ovf & ~clear_err);
      unf <= unf_evt | (unf & ~clear_err);
    end
  end

  // Output drive; an empty stack presents zero rather than stale storage.
  always_comb begin
    top_data  = is_empty ? '0 : mem[top_idx];
    count     = cnt;
    empty     = is_empty;
    full      = is_full;
    overflow  = ovf;
    underflow = unf;
  end

endmodule

// File: tb/tb_context_save_stack.sv
// Self-checking bench for context_save_stack (WIDTH=4, DEPTH=4).
// A queue-based reference model predicts each cycle's outputs into a
// scoreboard; tasks pop and compare after each falling edge.
module tb_context_save_stack;

  logic       clk;
  logic       reset;
  logic       push;
  logic [3:0] push_data;
  logic       pop;
  logic       clear_err;
  logic [3:0] top_data;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] top;
    logic [2:0] cnt;
    logic       e;
    logic       f;
    logic       o;
    logic       u;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl[$];
  logic       m_ovf;
  logic       m_unf;

  context_save_stack #(
    .WIDTH(4),
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear_err (clear_err),
    .top_data  (top_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t obs();
    obs = {top_data, count, empty, full, overflow, underflow};
  endfunction

  // Reference model: a growable queue used as a 4-deep stack.
  function automatic exp_t model_step(input logic p, input logic [3:0] d,
                                      input logic po, input logic clr,
                                      input logic rst);
    exp_t r;
    logic eo, eu;
    eo = 1'b0;
    eu = 1'b0;
    if (rst) begin
      mdl.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && po && mdl.size() > 0) mdl[mdl.size()-1] = d;
      else if (p) begin
        if (mdl.size() < 4) mdl.push_back(d);
        else eo = 1'b1;
      end else if (po) begin
        if (mdl.size() > 0) void'(mdl.pop_back());
        else eu = 1'b1;
      end
      m_ovf = eo | (m_ovf & ~clr);
      m_unf = eu | (m_unf & ~clr);
    end
    r.top = (mdl.size() > 0) ? mdl[mdl.size()-1] : 4'h0;
    r.cnt = 3'(mdl.size());
    r.e   = (mdl.size() == 0);
    r.f   = (mdl.size() == 4);
    r.o   = m_ovf;
    r.u   = m_unf;
    return r;
  endfunction

  // Drive one request across one falling edge and record the prediction.
  task automatic step(input logic p, input logic [3:0] d, input logic po,
                      input logic clr, input logic rst);
    push      = p;
    push_data = d;
    pop       = po;
    clear_err = clr;
    reset     = rst;
    sb.push_back(model_step(p, d, po, clr, rst));
    @(negedge clk);
    #1;
    push      = 1'b0;
    push_data = 4'h0;
    pop       = 1'b0;
    clear_err = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, g;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL reset_sb got=%h want=%h", g, e); end
    total++;
    if (top_data !== 4'h0) begin bad++; $display("FAIL reset_top got=%h want=0", top_data); end
    total++;
    if ({empty, full, count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL reset_status got e=%b f=%b c=%0d want e=1 f=0 c=0", empty, full, count);
    end
  endtask

  task automatic test_lifo();
    exp_t e, g;
    logic [3:0] vals[3] = '{4'h1, 4'h2, 4'h3};
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    foreach (vals[i]) begin
      step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); g = obs(); total++;
      if (g !== e) begin bad++; $display("FAIL lifo_push%0d got=%h want=%h", i, g, e); end
    end
    total++;
    if (count !== 3'd3 || top_data !== 4'h3) begin
      bad++; $display("FAIL lifo_after_push got c=%0d t=%h want c=3 t=3", count, top_data);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); g = obs(); total++;
      if (g !== e) begin bad++; $display("FAIL lifo_pop%0d got=%h want=%h", i, g, e); end
    end
    total++;
    if (count !== 3'd1 || top_data !== 4'h1) begin
      bad++; $display("FAIL lifo_after_pop got c=%0d t=%h want c=1 t=1", count, top_data);
    end
  endtask

  task automatic test_overflow();
    exp_t e, g;
    logic [3:0] vals[5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    foreach (vals[i]) begin
      step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); g = obs(); total++;
      if (g !== e) begin bad++; $display("FAIL ovf_push%0d got=%h want=%h", i, g, e); end
      if (i == 3) begin
        total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_full got f=%b o=%b want f=1 o=0", full, overflow);
        end
      end
    end
    total++;
    if (overflow !== 1'b1 || top_data !== 4'hD || count !== 3'd4) begin
      bad++; $display("FAIL ovf_drop got o=%b t=%h c=%0d want o=1 t=d c=4", overflow, top_data, count);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL ovf_clear_sb got=%h want=%h", g, e); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_swap_full();
    exp_t e, g;
    // Stack is full with top 0xD from the previous task.
    step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL swap_full_sb got=%h want=%h", g, e); end
    total++;
    if (count !== 3'd4 || top_data !== 4'h7 || overflow !== 1'b0) begin
      bad++; $display("FAIL swap_full got c=%0d t=%h o=%b want c=4 t=7 o=0", count, top_data, overflow);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL swap_then_pop got=%h want=%h", g, e); end
  endtask

  task automatic test_underflow();
    exp_t e, g;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); void'(sb.pop_front());
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL unf_pop_sb got=%h want=%h", g, e); end
    total++;
    if (underflow !== 1'b1 || count !== 3'd0 || top_data !== 4'h0) begin
      bad++; $display("FAIL unf_pop got u=%b c=%0d t=%h want u=1 c=0 t=0", underflow, count, top_data);
    end
    step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL unf_swap_sb got=%h want=%h", g, e); end
    total++;
    if (count !== 3'd1 || top_data !== 4'h5 || underflow !== 1'b1) begin
      bad++; $display("FAIL unf_swap_empty got c=%0d t=%h u=%b want c=1 t=5 u=1", count, top_data, underflow);
    end
  endtask

  task automatic test_clear_collision();
    exp_t e, g;
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL clr_coll_sb got=%h want=%h", g, e); end
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL clr_coll got u=%b want 1", underflow); end
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (underflow !== 1'b0 || g !== e) begin
      bad++; $display("FAIL clr_plain got u=%b sb=%h want u=0 sb=%h", underflow, g, e);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL rmid_fill got=%h want=%h", g, e); end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0); void'(sb.pop_front());
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); g = obs(); total++;
    if (g !== e) begin bad++; $display("FAIL rmid_sb got=%h want=%h", g, e); end
    total++;
    if ({count, empty, top_data, overflow, underflow} !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmid got c=%0d e=%b t=%h o=%b u=%b want c=0 e=1 t=0 o=0 u=0",
                      count, empty, top_data, overflow, underflow);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    logic p, po, clr;
    logic [3:0] d;
    for (int i = 0; i < 300; i++) begin
      p   = ($urandom_range(0, 99) < 50);
      po  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 10);
      d   = 4'($urandom_range(0, 15));
      step(p, d, po, clr, ($urandom_range(0, 99) < 2));
      e = sb.pop_front(); g = obs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL b2b_%0d got=%h want=%h (p=%b po=%b clr=%b d=%h)", i, g, e, p, po, clr, d);
      end
    end
  endtask

  initial begin
    push = 1'b0; push_data = 4'h0; pop = 1'b0; clear_err = 1'b0; reset = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_swap_full();
    test_underflow();
    test_clear_collision();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
